ram_arbiter: RTL and testbench

- Shares the single 256x12 program/data RAM between two requesters: the CPU memory path (MAR/MDR side) and an external program loader.
- Sits between both requesters and the RAM. It drives the RAM address, data, chip-enable and write-enable.
- Arbitrates round-robin with a burst limit, so neither side starves the other.
- A prog_mode input locks the RAM to the loader while a program is being written.

---
 rtl/ram_arbiter_pkg.sv | 17 +
 rtl/ram_arb_port.sv | 39 +++
 rtl/ram_arbiter.sv | 159 +++++++++++++++
 tb/tb_ram_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the program/data RAM arbiter: owner encoding and default bus widths.
package ram_arbiter_pkg;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 12;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_CPU  = 2'd1;
    localparam logic [1:0] OWN_LDR  = 2'd2;

    typedef enum logic [1:0] {
        ST_NONE = OWN_NONE,
        ST_CPU  = OWN_CPU,
        ST_LDR  = OWN_LDR
    } owner_e;

endpackage

// File: rtl/ram_arb_port.sv
// One requester side of the RAM arbiter: grant qualification plus the one-cycle read-return register.
module ram_arb_port
    import ram_arbiter_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          own,
    input  logic          req,
    input  logic          block,
    input  logic          we,
    input  logic [DW-1:0] ram_rdata,
    output logic          gnt,
    output logic          rvalid,
    output logic [DW-1:0] rdata
);

    logic          rvalid_q;
    logic [DW-1:0] rdata_q;

    assign gnt    = own & req & ~block;
    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;

    // RAM read is combinational from the address, so the edge ending the read transfer captures it.
    always_ff @(posedge clk) begin
        if (clr) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= gnt & ~we;
            if (gnt & ~we) begin
                rdata_q <= ram_rdata;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter with burst limit sharing the program/data RAM between the CPU and the program loader.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int AW        = AW_DEF,
    parameter int DW        = DW_DEF,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          prog_mode,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_gnt,
    output logic          ld_rvalid,
    output logic [DW-1:0] ld_rdata,
    output logic          ram_ce,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic [1:0]    owner
);

    owner_e        owner_q;
    owner_e        last_q;
    logic [3:0]    burst_q;
    logic [4:0]    burst_inc;
    logic [AW-1:0] addr_hold_q;
    logic [DW-1:0] wdata_hold_q;

    logic          cpu_eff;
    logic [1:0]    own_v, req_v, blk_v, we_v, gnt_v, rvalid_v;
    logic [DW-1:0] rdata_v [2];

    logic          xfer;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    assign cpu_eff   = cpu_req & ~prog_mode;
    assign burst_inc = {1'b0, burst_q} + 5'd1;

    // Index 0 is the CPU side, index 1 the loader side.
    assign own_v = {owner_q == ST_LDR, owner_q == ST_CPU};
    assign req_v = {ld_req, cpu_req};
    assign blk_v = {1'b0, prog_mode};
    assign we_v  = {ld_we, cpu_we};

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        ram_arb_port #(.DW(DW)) u_port (
            .clk       (clk),
            .clr       (clr),
            .own       (own_v[gi]),
            .req       (req_v[gi]),
            .block     (blk_v[gi]),
            .we        (we_v[gi]),
            .ram_rdata (ram_rdata),
            .gnt       (gnt_v[gi]),
            .rvalid    (rvalid_v[gi]),
            .rdata     (rdata_v[gi])
        );
    end

    assign cpu_gnt    = gnt_v[0];
    assign ld_gnt     = gnt_v[1];
    assign cpu_rvalid = rvalid_v[0];
    assign ld_rvalid  = rvalid_v[1];
    assign cpu_rdata  = rdata_v[0];
    assign ld_rdata   = rdata_v[1];
    assign owner      = owner_q;

    // At most one grant is ever high, so a simple priority mux suffices.
    assign xfer      = cpu_gnt | ld_gnt;
    assign sel_we    = cpu_gnt ? cpu_we    : ld_we;
    assign sel_addr  = cpu_gnt ? cpu_addr  : ld_addr;
    assign sel_wdata = cpu_gnt ? cpu_wdata : ld_wdata;

    assign ram_we    = xfer & sel_we;
    assign ram_ce    = xfer & ~sel_we;
    assign ram_addr  = xfer ? sel_addr  : addr_hold_q;
    assign ram_wdata = xfer ? sel_wdata : wdata_hold_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            addr_hold_q  <= '0;
            wdata_hold_q <= '0;
        end else if (xfer) begin
            addr_hold_q  <= sel_addr;
            wdata_hold_q <= sel_wdata;
        end
    end

    // Owner FSM; burst_q only advances while the other side is waiting.
    always_ff @(posedge clk) begin
        if (clr) begin
            owner_q <= ST_NONE;
            last_q  <= ST_LDR;
            burst_q <= '0;
        end else begin
            case (owner_q)
                ST_NONE: begin
                    burst_q <= '0;
                    if (cpu_eff && ld_req) begin
                        owner_q <= (last_q == ST_CPU) ? ST_LDR : ST_CPU;
                    end else if (cpu_eff) begin
                        owner_q <= ST_CPU;
                    end else if (ld_req) begin
                        owner_q <= ST_LDR;
                    end
                end
                ST_CPU: begin
                    if (!cpu_eff) begin
                        owner_q <= ld_req ? ST_LDR : ST_NONE;
                        last_q  <= ST_CPU;
                        burst_q <= '0;
                    end else if (ld_req && cpu_gnt) begin
                        if (burst_inc >= 5'(MAX_BURST)) begin
                            owner_q <= ST_LDR;
                            last_q  <= ST_CPU;
                            burst_q <= '0;
                        end else begin
                            burst_q <= burst_inc[3:0];
                        end
                    end
                end
                ST_LDR: begin
                    if (!ld_req) begin
                        owner_q <= cpu_eff ? ST_CPU : ST_NONE;
                        last_q  <= ST_LDR;
                        burst_q <= '0;
                    end else if (cpu_eff && ld_gnt) begin
                        if (burst_inc >= 5'(MAX_BURST)) begin
                            owner_q <= ST_CPU;
                            last_q  <= ST_LDR;
                            burst_q <= '0;
                        end else begin
                            burst_q <= burst_inc[3:0];
                        end
                    end
                end
                default: begin
                    owner_q <= ST_NONE;
                    burst_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 256x12 RAM attached to the RAM port.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        prog_mode = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [7:0]  cpu_addr = '0;
    logic [11:0] cpu_wdata = '0;
    logic        cpu_gnt, cpu_rvalid;
    logic [11:0] cpu_rdata;
    logic        ld_req = 1'b0, ld_we = 1'b0;
    logic [7:0]  ld_addr = '0;
    logic [11:0] ld_wdata = '0;
    logic        ld_gnt, ld_rvalid;
    logic [11:0] ld_rdata;
    logic        ram_ce, ram_we;
    logic [7:0]  ram_addr;
    logic [11:0] ram_wdata, ram_rdata;
    logic [1:0]  owner;

    logic [11:0] mem [256];
    logic        pre_we = 1'b0;
    logic [7:0]  pre_addr = '0;
    logic [11:0] pre_data = '0;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign ram_rdata = mem[ram_addr];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        else if (pre_we) mem[pre_addr] <= pre_data;
    end

    ram_arbiter #(.AW(8), .DW(12), .MAX_BURST(4)) dut (
        .clk(clk), .clr(clr), .prog_mode(prog_mode),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .owner(owner)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int ck, lk, a, cyc, e;
        logic seen, got;

        for (int i = 0; i < 256; i++) mem[i] = '0;
        tick();
        tick();
        clr = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_owner", owner, 0);
        check("rst_cpu_gnt", cpu_gnt, 0);
        check("rst_ld_gnt", ld_gnt, 0);
        check("rst_cpu_rvalid", cpu_rvalid, 0);
        check("rst_ld_rvalid", ld_rvalid, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        $display("txn reset: owner=%0d", owner);

        // Single CPU read of a preloaded location
        tick();
        pre_we = 1'b1; pre_addr = 8'h10; pre_data = 12'hABC;
        tick();
        pre_we = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
        @(negedge clk);
        check("rd_gnt_c0", cpu_gnt, 0);
        tick();
        @(negedge clk);
        check("rd_gnt_c1", cpu_gnt, 1);
        check("rd_owner_c1", owner, 1);
        check("rd_ce_c1", ram_ce, 1);
        check("rd_we_c1", ram_we, 0);
        check("rd_addr_c1", ram_addr, 8'h10);
        tick();
        cpu_req = 1'b0;
        @(negedge clk);
        check("rd_rvalid_c2", cpu_rvalid, 1);
        check("rd_rdata_c2", cpu_rdata, 12'hABC);
        check("rd_we_c2", ram_we, 0);
        tick();
        @(negedge clk);
        check("rd_rvalid_c3", cpu_rvalid, 0);
        check("rd_rdata_hold", cpu_rdata, 12'hABC);
        check("rd_owner_c3", owner, 0);
        $display("txn cpu read: addr=0x10 data=0x%0h", cpu_rdata);

        // Contention: both write continuously, CPU first after reset
        clr = 1'b1;
        tick();
        clr = 1'b0;
        ck = 0; lk = 0;
        for (int c = 0; c < 13; c++) begin
            cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'(8'h20 + ck); cpu_wdata = 12'(12'h100 + ck);
            ld_req  = 1'b1; ld_we  = 1'b1; ld_addr  = 8'(8'h40 + lk);  ld_wdata  = 12'(12'h200 + lk);
            @(negedge clk);
            e = (c == 0) ? 0 : ((((c - 1) / 4) % 2 == 0) ? 1 : 2);
            check($sformatf("cont_cpu_gnt_c%0d", c), cpu_gnt, (e == 1) ? 1 : 0);
            check($sformatf("cont_ld_gnt_c%0d", c), ld_gnt, (e == 2) ? 1 : 0);
            $display("txn contention cycle %0d: cpu_gnt=%0b ld_gnt=%0b", c, cpu_gnt, ld_gnt);
            if (e == 1) ck++;
            if (e == 2) lk++;
            tick();
        end
        cpu_req = 1'b0; ld_req = 1'b0;
        tick();
        tick();
        for (int k = 0; k < 8; k++) check($sformatf("cont_mem_cpu%0d", k), mem[8'h20 + k], 12'h100 + k);
        for (int k = 0; k < 4; k++) check($sformatf("cont_mem_ld%0d", k), mem[8'h40 + k], 12'h200 + k);

        // Loader program load under prog_mode with the CPU asking throughout
        prog_mode = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h05;
        ld_req = 1'b1; ld_we = 1'b1;
        a = 0; cyc = 0; seen = 1'b0;
        while (a < 256 && cyc < 400) begin
            ld_addr = a[7:0]; ld_wdata = a[11:0] ^ 12'hFFF;
            @(negedge clk);
            if (cpu_gnt) seen = 1'b1;
            if (ld_gnt) a++;
            cyc++;
            tick();
        end
        check("pm_load_count", a, 256);
        check("pm_cpu_gnt_never", seen, 0);
        check("pm_mem05", mem[5], 12'hFFA);
        check("pm_memFF", mem[255], 12'hF00);
        $display("txn program load: %0d words in %0d cycles", a, cyc);
        ld_req = 1'b0;
        prog_mode = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (cpu_rvalid) got = 1'b1;
            else tick();
        end
        check("pm_cpu_rd_seen", got, 1);
        check("pm_cpu_rd_data", cpu_rdata, 12'hFFA);
        $display("txn cpu read after load: addr=0x05 data=0x%0h", cpu_rdata);

        // prog_mode rising while the CPU owns mid-burst
        tick();
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 8'h80;
        @(negedge clk);
        check("pmr_cpu_gnt_before", cpu_gnt, 1);
        check("pmr_ld_gnt_before", ld_gnt, 0);
        tick();
        prog_mode = 1'b1;
        @(negedge clk);
        check("pmr_cpu_gnt_same", cpu_gnt, 0);
        check("pmr_ld_gnt_same", ld_gnt, 0);
        check("pmr_owner_same", owner, 1);
        check("pmr_ram_ce_same", ram_ce, 0);
        tick();
        @(negedge clk);
        check("pmr_owner_next", owner, 2);
        check("pmr_ld_gnt_next", ld_gnt, 1);
        check("pmr_addr_next", ram_addr, 8'h80);
        tick();
        @(negedge clk);
        check("pmr_ld_rvalid", ld_rvalid, 1);
        check("pmr_ld_rdata", ld_rdata, 12'hF7F);
        $display("txn loader read under prog_mode: addr=0x80 data=0x%0h", ld_rdata);
        tick();
        cpu_req = 1'b0; ld_req = 1'b0; prog_mode = 1'b0;
        tick();
        tick();

        // Idle other side: CPU keeps the RAM for 20 consecutive writes
        cpu_req = 1'b1; cpu_we = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            cpu_addr = 8'(8'h90 + k); cpu_wdata = 12'(k);
            @(negedge clk);
            if (k == 0) begin
                check("idle_gnt_c0", cpu_gnt, 0);
            end else begin
                check($sformatf("idle_gnt_c%0d", k), cpu_gnt, 1);
                check($sformatf("idle_owner_c%0d", k), owner, 1);
            end
            tick();
        end
        cpu_req = 1'b0;
        tick();
        check("idle_mem_first", mem[8'h91], 12'd1);
        check("idle_mem_last", mem[8'h90 + 20], 12'd20);
        $display("txn idle owner: 20 CPU writes");
        tick();

        // Reset in the middle of a loader burst
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h00;
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 8'h80;
        tick();
        @(negedge clk);
        check("mrst_ld_gnt_a", ld_gnt, 1);
        tick();
        clr = 1'b1;
        @(negedge clk);
        check("mrst_ld_gnt_b", ld_gnt, 1);
        tick();
        clr = 1'b0;
        @(negedge clk);
        check("mrst_owner", owner, 0);
        check("mrst_cpu_gnt", cpu_gnt, 0);
        check("mrst_ld_gnt", ld_gnt, 0);
        check("mrst_ld_rvalid", ld_rvalid, 0);
        check("mrst_cpu_rvalid", cpu_rvalid, 0);
        check("mrst_ld_rdata", ld_rdata, 0);
        $display("txn reset mid-burst: owner=%0d", owner);
        cpu_req = 1'b0; ld_req = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
